// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch (read-only)
// and the data port. One access is in flight at a time. Each access drives mem_en
// for exactly one cycle, waits MEM_LAT cycles, then pulses the owner's ack.
// The data port has priority. A starvation counter lets fetch win once after
// STARVE_MAX consecutive data grants taken while fetch was waiting.
// A requester whose ack is high is skipped at that IDLE edge. That prevents a
// duplicate issue while the requester is still taking its request down.

module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dm
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  logic [0:0]       stateR;
  logic [CNT_W-1:0] cntR;
  logic [STV_W-1:0] starveCntR;
  logic             wrR;

  logic             dmReqS;
  logic             dmEligS;
  logic             ifEligS;
  logic             pickIfS;
  logic             pickDmS;
  logic [STV_W-1:0] starveNxtS;

  assign dmReqS   = dm_re | dm_we;
  assign dmEligS  = dmReqS & ~dm_ack;
  assign ifEligS  = if_req & ~if_ack;
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dmReqS & ~dm_ack;
  assign busy     = (stateR != ST_IDLE);

  // Choose the winner among the eligible requesters. The data port wins unless fetch has starved.
  always_comb begin
    pickIfS = 1'b0;
    pickDmS = 1'b0;
    if (ifEligS && (!dmEligS || (starveCntR == STV_MAX))) begin
      pickIfS = 1'b1;
    end else if (dmEligS) begin
      pickDmS = 1'b1;
    end else begin
      pickIfS = 1'b0;
      pickDmS = 1'b0;
    end
  end

  // Next starvation count. It only moves in IDLE and saturates at STARVE_MAX.
  always_comb begin
    starveNxtS = starveCntR;
    if (stateR == ST_IDLE) begin
      if (pickIfS || !if_req) begin
        starveNxtS = '0;
      end else if (pickDmS && (starveCntR != STV_MAX)) begin
        starveNxtS = starveCntR + STV_W'(1'b1);
      end else begin
        starveNxtS = starveCntR;
      end
    end else begin
      starveNxtS = starveCntR;
    end
  end

  // Access sequencer: issue in IDLE, count down the memory latency in WAIT, then deliver data and ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR     <= ST_IDLE;
      cntR       <= '0;
      starveCntR <= '0;
      wrR        <= 1'b0;
      if_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_rdata   <= '0;
      dm_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_dm   <= 1'b0;
    end else begin
      starveCntR <= starveNxtS;
      case (stateR)
        ST_IDLE: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          if (pickIfS || pickDmS) begin
            stateR    <= ST_WAIT;
            cntR      <= LAT_INIT;
            mem_en    <= 1'b1;
            grant_dm  <= pickDmS;
            wrR       <= pickDmS & dm_we;
            mem_we    <= pickDmS & dm_we;
            mem_addr  <= pickDmS ? dm_addr : if_addr;
            mem_wdata <= pickDmS ? dm_wdata : '0;
          end
        end
        ST_WAIT: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (cntR != '0) begin
            cntR <= cntR - CNT_W'(1'b1);
          end else begin
            stateR <= ST_IDLE;
            if (grant_dm) begin
              dm_ack <= 1'b1;
              if (!wrR) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          stateR <= ST_IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Two arbiters, one with MEM_LAT=1 and one with MEM_LAT=3, share the same request
// stimulus. Each arbiter has its own memory responder. A transaction-level model
// predicts every output of every instance on every cycle, and directed sequences
// pin the key timings with literal values.

module tb_mem_port_arbiter;

  localparam int NI         = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req;
  logic [15:0] if_addr;
  logic dm_re, dm_we;
  logic [15:0] dm_addr, dm_wdata;

  logic [15:0] oIfRdata  [NI];
  logic        oIfAck    [NI];
  logic        oIfStall  [NI];
  logic [15:0] oDmRdata  [NI];
  logic        oDmAck    [NI];
  logic        oDmStall  [NI];
  logic        oMemEn    [NI];
  logic        oMemWe    [NI];
  logic [15:0] oMemAddr  [NI];
  logic [15:0] oMemWdata [NI];
  logic [15:0] memRdata  [NI];
  logic        oBusy     [NI];
  logic        oGrant    [NI];

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] memInit(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s inst%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int L = (g == 0) ? 1 : 3;
    logic [15:0] memArr [65536];
    logic [15:0] pipe   [4];

    initial begin
      for (int i = 0; i < 65536; i++) memArr[i] = memInit(16'(i));
    end

    // Memory responder: returns read data MEM_LAT cycles after sampling mem_en, noise otherwise.
    always @(posedge clk) begin
      if (oMemEn[g] && oMemWe[g]) memArr[oMemAddr[g]] = oMemWdata[g];
      pipe[0] <= (oMemEn[g] && !oMemWe[g]) ? memArr[oMemAddr[g]] : 16'($urandom);
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign memRdata[g] = pipe[L-1];

    mem_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .MEM_LAT(L), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(oIfRdata[g]),
      .if_ack(oIfAck[g]), .if_stall(oIfStall[g]),
      .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(oDmRdata[g]), .dm_ack(oDmAck[g]), .dm_stall(oDmStall[g]),
      .mem_en(oMemEn[g]), .mem_we(oMemWe[g]), .mem_addr(oMemAddr[g]),
      .mem_wdata(oMemWdata[g]), .mem_rdata(memRdata[g]),
      .busy(oBusy[g]), .grant_dm(oGrant[g])
    );
  end

  // ---------------- transaction-level reference model ----------------
  logic [15:0] refMem [NI][65536];
  bit          inF   [NI];
  bit          ownDm [NI];
  bit          wr    [NI];
  logic [15:0] adr   [NI];
  logic [15:0] wd    [NI];
  int          iss   [NI];
  int          starve[NI];
  logic        eIfAck[NI], eDmAck[NI], eMemEn[NI], eBusy[NI], eGrant[NI];
  logic [15:0] eIfRd [NI], eDmRd [NI];
  int          cyc = 0;

  initial begin : model
    bit sRst, sIfReq, sRe, sWe;
    logic [15:0] sIfAddr, sDmAddr, sWdata;
    bit pAckIf, pAckDm, dmE, ifE, gr, gDm;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 65536; i++) refMem[k][i] = memInit(16'(i));
      inF[k] = 1'b0; eIfAck[k] = 1'b0; eDmAck[k] = 1'b0; eMemEn[k] = 1'b0;
      eBusy[k] = 1'b0; eGrant[k] = 1'b0; eIfRd[k] = 16'h0000; eDmRd[k] = 16'h0000;
      starve[k] = 0; iss[k] = 0; ownDm[k] = 1'b0; wr[k] = 1'b0; adr[k] = 16'h0000; wd[k] = 16'h0000;
    end
    forever begin
      @(posedge clk);
      sRst = rst_n; sIfReq = if_req; sRe = dm_re; sWe = dm_we;
      sIfAddr = if_addr; sDmAddr = dm_addr; sWdata = dm_wdata;
      cyc++;
      for (int k = 0; k < NI; k++) begin
        if (!sRst) begin
          inF[k] = 1'b0; eIfAck[k] = 1'b0; eDmAck[k] = 1'b0; eMemEn[k] = 1'b0;
          eBusy[k] = 1'b0; eGrant[k] = 1'b0; eIfRd[k] = 16'h0000; eDmRd[k] = 16'h0000;
          starve[k] = 0;
        end else begin
          pAckIf = eIfAck[k]; pAckDm = eDmAck[k];
          eIfAck[k] = 1'b0; eDmAck[k] = 1'b0; eMemEn[k] = 1'b0;
          if (inF[k]) begin
            if (cyc == iss[k] + latOf(k) + 1) begin
              if (ownDm[k]) begin
                eDmAck[k] = 1'b1;
                if (!wr[k]) eDmRd[k] = refMem[k][adr[k]];
              end else begin
                eIfAck[k] = 1'b1;
                eIfRd[k] = refMem[k][adr[k]];
              end
              inF[k] = 1'b0;
            end
          end else begin
            dmE = (sRe || sWe) && !pAckDm;
            ifE = sIfReq && !pAckIf;
            if (ifE && (!dmE || starve[k] == STARVE_MAX)) begin
              gr = 1'b1; gDm = 1'b0; starve[k] = 0;
            end else if (dmE) begin
              gr = 1'b1; gDm = 1'b1;
              if (sIfReq) starve[k] = (starve[k] < STARVE_MAX) ? starve[k] + 1 : STARVE_MAX;
              else starve[k] = 0;
            end else begin
              gr = 1'b0; gDm = 1'b0;
              if (!sIfReq) starve[k] = 0;
            end
            if (gr) begin
              inF[k] = 1'b1; iss[k] = cyc; ownDm[k] = gDm;
              wr[k] = gDm && sWe;
              adr[k] = gDm ? sDmAddr : sIfAddr;
              wd[k] = sWdata;
              eMemEn[k] = 1'b1; eGrant[k] = gDm;
              if (wr[k]) refMem[k][adr[k]] = wd[k];
            end
          end
          eBusy[k] = inF[k];
        end
      end
      #1;
      for (int k = 0; k < NI; k++) begin
        chk("if_ack",   k, oIfAck[k],   eIfAck[k]);
        chk("dm_ack",   k, oDmAck[k],   eDmAck[k]);
        chk("mem_en",   k, oMemEn[k],   eMemEn[k]);
        chk("busy",     k, oBusy[k],    eBusy[k]);
        chk("grant_dm", k, oGrant[k],   eGrant[k]);
        chk("if_rdata", k, oIfRdata[k], eIfRd[k]);
        chk("dm_rdata", k, oDmRdata[k], eDmRd[k]);
        chk("if_stall", k, oIfStall[k], if_req & ~eIfAck[k]);
        chk("dm_stall", k, oDmStall[k], (dm_re | dm_we) & ~eDmAck[k]);
        if (eMemEn[k]) begin
          chk("mem_we",   k, oMemWe[k],   wr[k]);
          chk("mem_addr", k, oMemAddr[k], adr[k]);
          if (wr[k]) chk("mem_wdata", k, oMemWdata[k], wd[k]);
        end
      end
    end
  end

  // ---------------- stimulus and literal checks ----------------
  task automatic idle(input int n);
    if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic atEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic zeroCheck(input int k);
    chk("rst_if_ack",   k, oIfAck[k],    32'd0);
    chk("rst_dm_ack",   k, oDmAck[k],    32'd0);
    chk("rst_mem_en",   k, oMemEn[k],    32'd0);
    chk("rst_mem_we",   k, oMemWe[k],    32'd0);
    chk("rst_mem_addr", k, oMemAddr[k],  32'd0);
    chk("rst_busy",     k, oBusy[k],     32'd0);
    chk("rst_grant",    k, oGrant[k],    32'd0);
    chk("rst_if_rdata", k, oIfRdata[k],  32'd0);
    chk("rst_dm_rdata", k, oDmRdata[k],  32'd0);
    chk("rst_stalls",   k, {oIfStall[k], oDmStall[k]}, 32'd0);
  endtask

  initial begin : stim
    int busyCnt, acks, issues;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 16'h0000;
    dm_re = 1'b0; dm_we = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) zeroCheck(k);
    rst_n = 1'b1;
    idle(2);

    // Fetch read at 0x0010, latency 1.
    if_req = 1'b1; if_addr = 16'h0010;
    atEdge();
    chk("t1_mem_en", 0, oMemEn[0], 32'd1);
    chk("t1_mem_addr", 0, oMemAddr[0], 32'h0010);
    chk("t1_mem_we", 0, oMemWe[0], 32'd0);
    chk("t1_if_stall_e0", 0, oIfStall[0], 32'd1);
    atEdge();
    chk("t1_mem_en_e1", 0, oMemEn[0], 32'd0);
    chk("t1_if_ack_e1", 0, oIfAck[0], 32'd0);
    chk("t1_if_stall_e1", 0, oIfStall[0], 32'd1);
    atEdge();
    chk("t1_if_ack_e2", 0, oIfAck[0], 32'd1);
    chk("t1_if_rdata", 0, oIfRdata[0], 32'hBEEF);
    chk("t1_if_stall_e2", 0, oIfStall[0], 32'd0);
    @(negedge clk);
    idle(8);

    // Data write 0x1234 to 0x0020.
    dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    atEdge();
    chk("t2_mem_en", 0, oMemEn[0], 32'd1);
    chk("t2_mem_we", 0, oMemWe[0], 32'd1);
    chk("t2_mem_wdata", 0, oMemWdata[0], 32'h1234);
    chk("t2_mem_addr", 0, oMemAddr[0], 32'h0020);
    atEdge();
    chk("t2_dm_ack_e1", 0, oDmAck[0], 32'd0);
    atEdge();
    chk("t2_dm_ack_e2", 0, oDmAck[0], 32'd1);
    chk("t2_dm_rdata_kept", 0, oDmRdata[0], 32'h0000);
    @(negedge clk);
    idle(8);

    // Data read at 0x00FF on the latency-3 instance.
    dm_re = 1'b1; dm_addr = 16'h00FF;
    busyCnt = 0;
    for (int e = 0; e < 4; e++) begin
      atEdge();
      if (oBusy[1]) busyCnt++;
      chk("t4_dm_ack_early", 1, oDmAck[1], 32'd0);
    end
    atEdge();
    if (oBusy[1]) busyCnt++;
    chk("t4_dm_ack_e4", 1, oDmAck[1], 32'd1);
    chk("t4_dm_rdata", 1, oDmRdata[1], memInit(16'h00FF));
    chk("t4_busy_cycles", 1, busyCnt, 32'd4);
    @(negedge clk);
    idle(8);

    // Read and write together: a single write, acked once, no re-issue while acked.
    dm_re = 1'b1; dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h5555;
    acks = 0; issues = 0;
    for (int e = 0; e < 4; e++) begin
      atEdge();
      if (oMemEn[0]) issues++;
      if (oDmAck[0]) acks++;
      if (e == 0) chk("t6_mem_we", 0, oMemWe[0], 32'd1);
    end
    chk("t6_ack_count", 0, acks, 32'd1);
    chk("t6_issue_count", 0, issues, 32'd1);
    @(negedge clk);
    idle(8);

    // Both requesters held high.
    if_req = 1'b1; if_addr = 16'h0040; dm_re = 1'b1; dm_addr = 16'h0050;
    repeat (40) @(negedge clk);
    idle(8);

    // Reset in the middle of an access.
    dm_re = 1'b1; dm_addr = 16'h0060;
    atEdge();
    @(negedge clk);
    rst_n = 1'b0; dm_re = 1'b0; if_req = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) zeroCheck(k);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    atEdge();
    chk("t5_mem_en", 0, oMemEn[0], 32'd1);
    atEdge();
    atEdge();
    chk("t5_if_ack", 0, oIfAck[0], 32'd1);
    chk("t5_if_rdata", 0, oIfRdata[0], 32'hBEEF);
    @(negedge clk);
    idle(8);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) if_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) if_addr = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) dm_re = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) dm_we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) dm_addr = 16'($urandom_range(0, 31));
      dm_wdata = 16'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
